sum_tx_sequencer: RTL
=====================

// Module: sum_tx_sequencer
// PURPOSE
//  Controller between the operand-latch/adder datapath and the UART transmitter.
//  Captures operands A and B on save strobes and snapshots A, B and A+B into a frame.
//  Sequences the frame to the UART as 8 ASCII bytes: hexA '+' hexB '=' sum_hi sum_lo CR LF.
//  Runs the UART start/busy handshake.
//  Sits inside top, driving the existing UART TX core (tx_data/tx_start in, tx_busy out).
// PARAMETERS
//  DATA_W      4   operand width; the sum is DATA_W+1 bits; the frame format is fixed for DATA_W=4
//  SYNC_STAGES 2   synchroniser flops on save_a_n/save_b_n/send_req
//  BUSY_WAIT   4   cycles to wait for tx_busy to rise after tx_start before treating the byte as taken
//  AUTO_SEND   0   1: a save_b strobe also starts a frame, as if send_req had risen
// PORTS
//  clk       in   1       single clock, rising edge
//  reset     in   1       synchronous, active-high
//  data_in   in   DATA_W  operand value
//  save_a_n  in   1       async, active-low; falling edge loads reg_a
//  save_b_n  in   1       async, active-low; falling edge loads reg_b
//  send_req  in   1       async, active-high; rising edge requests one frame
//  tx_busy   in   1       UART TX busy
//  tx_data   out  8       byte presented to the UART
//  tx_start  out  1       one-cycle start pulse to the UART
//  reg_a     out  DATA_W  latched operand A
//  reg_b     out  DATA_W  latched operand B
//  sum       out  DATA_W+1  reg_a+reg_b, zero-extended, combinational from the regs
//  seq_busy  out  1       high from frame accept until the last byte completes
//  frame_done out 1       one-cycle pulse after byte 7 completes
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; byte index 0; synchronisers cleared to the inactive level.
//  Inputs: SYNC_STAGES-flop sync, then edge detect. A strobe acts SYNC_STAGES+1 cycles after the pin edge.
//  Saves: always accepted, including during a frame. Simultaneous A and B strobes load the same data_in.
//  FSM states: IDLE, LOAD, SEND, ACK, DRAIN.
//   IDLE:  send edge (or save_b edge with AUTO_SEND) -> LOAD. Otherwise stay.
//   LOAD:  snapshot reg_a, reg_b, sum into frame regs; idx=0; seq_busy=1; -> SEND.
//   SEND:  if !tx_busy, drive tx_data=byte[idx], pulse tx_start, clear the timer, -> ACK.
//          Else hold SEND.
//   ACK:   tx_busy=1 -> DRAIN.
//          Timer reaches BUSY_WAIT -> treat the byte as complete (same as the DRAIN exit).
//   DRAIN: tx_busy=0 -> if idx==7: pulse frame_done, seq_busy=0, -> IDLE.
//          Else idx++, -> SEND.
//  tx_data holds its value from the tx_start cycle until the next SEND. tx_start never lasts more than one cycle.
//  Frame bytes: hex digits 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
//   '+'=0x2B, '='=0x3D, CR=0x0D, LF=0x0A.
//   sum_hi = hex of the upper nibble of the zero-extended 8-bit sum (0 or 1).
//  In-flight frame is immutable: saves during a frame change reg_a/reg_b/sum only, not the frame.
//  send_req edges while seq_busy=1 are dropped (no queue). An edge arriving in the same cycle as frame_done is also dropped.
//  Reset mid-frame: all outputs 0 at the next edge; no further tx_start. A byte already started in the UART is not aborted.
// STRUCTURE
//  Package sum_uart_pkg: state enum, ASCII constants (PLUS, EQ, CR, LF), hex_to_ascii function, FRAME_LEN=8.
//  Sub-module sync_edge (SYNC_STAGES, POL): synchroniser plus edge detect, instantiated 3x.
//  Byte mux selected by idx lives in this module.
// TESTING
//  1 reset; A=3, B=5, send -> tx_data 33 2B 35 3D 30 38 0D 0A; one frame_done; seq_busy low after.
//  2 A=F, B=F, send -> 46 2B 46 3D 31 45 0D 0A; sum=0x1E.
//  3 send edge during byte 2, and again coincident with frame_done -> exactly one frame, 8 tx_start pulses.
//  4 save_a with data_in=9 during byte 4 -> frame still uses old A; reg_a=9; the next frame's byte0=0x39.
//  5 tx_busy held 0 -> each byte advances BUSY_WAIT cycles after tx_start; 8 bytes total.
//  6 reset at byte 3 -> all outputs 0 next cycle; no tx_start until a new send edge.

Source files
------------

// File: rtl/sum_tx_sequencer_pkg.sv
// Shared types, ASCII constants and the nibble-to-hex helper for the
// sum-to-UART frame sequencer.
package sum_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_ACK,
        ST_DRAIN
    } state_t;

    localparam int FRAME_LEN = 8;

    localparam logic [7:0] PLUS = 8'h2B;
    localparam logic [7:0] EQ   = 8'h3D;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;

    // Uppercase hex digit for one nibble: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/sum_tx_sequencer_if.sv
// Byte/start/busy handshake between the frame sequencer and the UART TX core.
interface sum_tx_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (output tx_data, output tx_start, input tx_busy);
    modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/sum_tx_sequencer_sync_edge.sv
// Synchroniser chain for an asynchronous pin followed by an edge detector.
// POL=1 reports rising edges, POL=0 reports falling edges (active-low pin).
module sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit POL         = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the chain; reset parks every flop at the inactive level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{~POL}};
            prev_q <= ~POL;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = (sync_q[SYNC_STAGES-1] == POL) && (prev_q != POL);

endmodule

// File: rtl/sum_tx_sequencer.sv
// Latches operands A/B, snapshots A, B and A+B into a frame and streams it
// to the UART as "hA+hB=SsCRLF", running the tx_start/tx_busy handshake.
module sum_tx_sequencer
    import sum_uart_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int BUSY_WAIT   = 4,
    parameter int AUTO_SEND   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 save_a_n,
    input  logic                 save_b_n,
    input  logic                 send_req,
    sum_tx_sequencer_if.master   tx_if,
    output logic [DATA_W-1:0]    reg_a,
    output logic [DATA_W-1:0]    reg_b,
    output logic [DATA_W:0]      sum,
    output logic                 seq_busy,
    output logic                 frame_done
);

    localparam int TW         = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam int TIMER_LAST = (BUSY_WAIT > 0) ? BUSY_WAIT - 1 : 0;

    logic             save_a_edge, save_b_edge, send_edge, start_req;
    logic [DATA_W-1:0] reg_a_q, reg_b_q;
    logic [DATA_W-1:0] frame_a_q, frame_b_q;
    logic [DATA_W:0]   frame_s_q;
    state_t           state_q;
    logic [2:0]       idx_q;
    logic [TW-1:0]    timer_q;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, seq_busy_q, frame_done_q;
    logic [7:0]       sum8;
    logic             last_byte, byte_done;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .POL(1'b0)) u_sync_a (
        .clk(clk), .reset(reset), .async_i(save_a_n), .edge_o(save_a_edge)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .POL(1'b0)) u_sync_b (
        .clk(clk), .reset(reset), .async_i(save_b_n), .edge_o(save_b_edge)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .POL(1'b1)) u_sync_s (
        .clk(clk), .reset(reset), .async_i(send_req), .edge_o(send_edge)
    );

    assign start_req = send_edge || ((AUTO_SEND != 0) && save_b_edge);

    // Operand latches accept strobes at any time; the frame snapshot is separate.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a_q <= '0;
            reg_b_q <= '0;
        end else begin
            if (save_a_edge) reg_a_q <= data_in;
            if (save_b_edge) reg_b_q <= data_in;
        end
    end

    // Byte mux: pick frame byte idx_q from the snapshot registers.
    always_comb begin
        sum8 = 8'(frame_s_q);
        case (idx_q)
            3'd0:    tx_data_d = hex_to_ascii(4'(frame_a_q));
            3'd1:    tx_data_d = PLUS;
            3'd2:    tx_data_d = hex_to_ascii(4'(frame_b_q));
            3'd3:    tx_data_d = EQ;
            3'd4:    tx_data_d = hex_to_ascii(sum8[7:4]);
            3'd5:    tx_data_d = hex_to_ascii(sum8[3:0]);
            3'd6:    tx_data_d = CR;
            default: tx_data_d = LF;
        endcase
    end

    // A byte is finished when busy falls in DRAIN or busy never rose within BUSY_WAIT.
    assign last_byte = (idx_q == 3'(FRAME_LEN - 1));
    assign byte_done = !tx_if.tx_busy &&
                       ((state_q == ST_DRAIN) ||
                        ((state_q == ST_ACK) && (timer_q == TW'(TIMER_LAST))));

    // Frame sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            seq_busy_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_a_q    <= '0;
            frame_b_q    <= '0;
            frame_s_q    <= '0;
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A request landing on the frame_done cycle is dropped.
                    if (start_req && !frame_done_q) begin
                        seq_busy_q <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    frame_a_q <= reg_a_q;
                    frame_b_q <= reg_b_q;
                    frame_s_q <= sum;
                    idx_q     <= '0;
                    state_q   <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_if.tx_busy) begin
                        tx_data_q  <= tx_data_d;
                        tx_start_q <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (tx_if.tx_busy) begin
                        state_q <= ST_DRAIN;
                    end else if (!byte_done) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_DRAIN: ;
                default: state_q <= ST_IDLE;
            endcase
            if (byte_done) begin
                if (last_byte) begin
                    frame_done_q <= 1'b1;
                    seq_busy_q   <= 1'b0;
                    state_q      <= ST_IDLE;
                end else begin
                    idx_q   <= idx_q + 3'd1;
                    state_q <= ST_SEND;
                end
            end
        end
    end

    assign tx_if.tx_data  = tx_data_q;
    assign tx_if.tx_start = tx_start_q;
    assign reg_a          = reg_a_q;
    assign reg_b          = reg_b_q;
    assign sum            = {1'b0, reg_a_q} + {1'b0, reg_b_q};
    assign seq_busy       = seq_busy_q;
    assign frame_done     = frame_done_q;

endmodule
